// File: rtl/reg_addr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_addr_arbiter
//
// Shares the register-address path that feeds BUFFER_5_BIT between two
// requesters: requester 0 is the DLX core and requester 1 is the sharpening
// engine. One requester owns the path per tenure. Each accepted beat of the
// owner is registered onto ADDR_OUT with ADDR_VLD and OWNER. Ownership
// alternates round-robin. While the other side is waiting, a tenure is capped
// at MAX_HOLD accepted beats.
//
// Parameters
//   ADDR_W    address width (register index)
//   MAX_HOLD  max accepted beats per tenure while the other requester waits
//
// Ports
//   CLK       single clock, rising edge
//   RESET     synchronous, active-high reset
//   REQ0      core request / beat valid
//   ADDR0     core register address
//   LAST0     core final beat of its burst (qualified by REQ0)
//   REQ1      engine request / beat valid
//   ADDR1     engine register address
//   LAST1     engine final beat of its burst (qualified by REQ1)
//   GNT0      core owns the path (registered)
//   GNT1      engine owns the path (registered)
//   ADDR_OUT  registered address of the last accepted beat
//   ADDR_VLD  ADDR_OUT carries a beat accepted in the previous cycle
//   OWNER     source of the current ADDR_OUT beat (0 = core, 1 = engine)
// ---------------------------------------------------------------------------
module reg_addr_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int MAX_HOLD = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic              LAST0,
    input  logic              REQ1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic              LAST1,
    output logic              GNT0,
    output logic              GNT1,
    output logic [ADDR_W-1:0] ADDR_OUT,
    output logic              ADDR_VLD,
    output logic              OWNER
);

    // The hold counter only has to reach MAX_HOLD-1, where it saturates.
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;
    logic              rr_ptr_nxt;
    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  hold_cnt_nxt;

    logic              own_req;
    logic              own_last;
    logic              other_req;
    logic              accept;
    logic              accept_src;
    logic [ADDR_W-1:0] accept_addr;
    logic              tenure_end;

    // Grants decode directly from the state register, so they are registered.
    // They cannot both be high because the states are exclusive.
    assign GNT0 = (state == OWN0);
    assign GNT1 = (state == OWN1);

    // Map the owner's and the waiting side's signals onto neutral names.
    // This lets the tenure-end rule be written once for both owners.
    // In IDLE nobody owns the path, so no beat can be accepted.
    always_comb begin
        own_req     = 1'b0;
        own_last    = 1'b0;
        other_req   = 1'b0;
        accept_src  = 1'b0;
        accept_addr = ADDR0;
        case (state)
            OWN0: begin
                own_req     = REQ0;
                own_last    = LAST0;
                other_req   = REQ1;
                accept_src  = 1'b0;
                accept_addr = ADDR0;
            end
            OWN1: begin
                own_req     = REQ1;
                own_last    = LAST1;
                other_req   = REQ0;
                accept_src  = 1'b1;
                accept_addr = ADDR1;
            end
            default: begin
            end
        endcase
    end

    // A tenure ends in any of three cases. The owner may drop its request.
    // The owner may flag the last beat of its burst. The owner may use up
    // its hold budget while the other side waits. A saturated counter makes
    // the forced release happen on the very beat the other side starts
    // waiting, even after a long solo stream.
    assign accept     = own_req;
    assign tenure_end = (state != IDLE) &&
                        (!own_req || own_last || (other_req && (hold_cnt == HOLD_LIMIT)));

    // Next-state logic. On a tenure end, the path hands over directly to a
    // waiting requester with no idle cycle between owners.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (REQ0 && REQ1) begin
                    state_nxt = rr_ptr ? OWN1 : OWN0;
                end else if (REQ0) begin
                    state_nxt = OWN0;
                end else if (REQ1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (tenure_end) begin
                    rr_ptr_nxt   = (state == OWN0);
                    hold_cnt_nxt = '0;
                    if (other_req) begin
                        state_nxt = (state == OWN0) ? OWN1 : OWN0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (accept && (hold_cnt != HOLD_LIMIT)) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers. If reset arrives mid-tenure, the grant is
    // dropped and the beat presented in that cycle is discarded. ADDR_OUT
    // keeps its last value across cycles that have no accepted beat.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            hold_cnt <= '0;
            ADDR_OUT <= '0;
            ADDR_VLD <= 1'b0;
            OWNER    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            ADDR_VLD <= accept;
            if (accept) begin
                ADDR_OUT <= accept_addr;
                OWNER    <= accept_src;
            end
        end
    end

endmodule

// File: tb/tb_reg_addr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_addr_arbiter
//
// Directed testbench for reg_addr_arbiter. It covers reset behaviour, a
// single requester, a tie between requesters, the hold bound, an unbounded
// solo stream, and reset during a tenure. A per-cycle monitor checks that
// the grants are never both high. It also checks that every ADDR_VLD beat
// matches the owner and address presented on the previous edge.
// ---------------------------------------------------------------------------
module tb_reg_addr_arbiter;

    logic       CLK;
    logic       RESET;
    logic       REQ0;
    logic [4:0] ADDR0;
    logic       LAST0;
    logic       REQ1;
    logic [4:0] ADDR1;
    logic       LAST1;
    logic       GNT0;
    logic       GNT1;
    logic [4:0] ADDR_OUT;
    logic       ADDR_VLD;
    logic       OWNER;

    int errors = 0;
    int checks = 0;

    reg_addr_arbiter #(
        .ADDR_W  (5),
        .MAX_HOLD(8)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .REQ0    (REQ0),
        .ADDR0   (ADDR0),
        .LAST0   (LAST0),
        .REQ1    (REQ1),
        .ADDR1   (ADDR1),
        .LAST1   (LAST1),
        .GNT0    (GNT0),
        .GNT1    (GNT1),
        .ADDR_OUT(ADDR_OUT),
        .ADDR_VLD(ADDR_VLD),
        .OWNER   (OWNER)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic rst,
                                 input logic r0, input logic [4:0] a0, input logic l0,
                                 input logic r1, input logic [4:0] a1, input logic l1);
        RESET = rst;
        REQ0  = r0;
        ADDR0 = a0;
        LAST0 = l0;
        REQ1  = r1;
        ADDR1 = a1;
        LAST1 = l1;
        @(posedge CLK);
        #1;
    endtask

    // Check the grants, the valid flag, the address and the owner together.
    task automatic checkAll(input string tag, input logic g0, input logic g1,
                            input logic vld, input logic [4:0] addr, input logic own);
        checkOutput({tag, ".gnt0"}, {7'd0, GNT0}, {7'd0, g0});
        checkOutput({tag, ".gnt1"}, {7'd0, GNT1}, {7'd0, g1});
        checkOutput({tag, ".vld"},  {7'd0, ADDR_VLD}, {7'd0, vld});
        checkOutput({tag, ".addr"}, {3'd0, ADDR_OUT}, {3'd0, addr});
        checkOutput({tag, ".owner"}, {7'd0, OWNER}, {7'd0, own});
    endtask

    // Per-cycle invariant monitor. Each rising edge records what the DUT
    // saw; the following falling edge checks the registered result.
    logic       mon_en = 1'b0;
    logic       p_rst, p_g0, p_g1, p_r0, p_r1;
    logic [4:0] p_a0, p_a1;
    logic       exp_vld;

    always @(posedge CLK) begin
        p_rst <= RESET;
        p_g0  <= GNT0;
        p_g1  <= GNT1;
        p_r0  <= REQ0;
        p_r1  <= REQ1;
        p_a0  <= ADDR0;
        p_a1  <= ADDR1;
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            checkOutput("inv.excl", {7'd0, GNT0 & GNT1}, 8'd0);
            exp_vld = !p_rst && ((p_g0 && p_r0) || (p_g1 && p_r1));
            checkOutput("inv.vld", {7'd0, ADDR_VLD}, {7'd0, exp_vld});
            if (exp_vld) begin
                checkOutput("inv.owner", {7'd0, OWNER}, {7'd0, p_g1});
                checkOutput("inv.addr", {3'd0, ADDR_OUT}, {3'd0, (p_g1 ? p_a1 : p_a0)});
            end
        end
    end

    initial begin
        RESET = 1'b1;
        REQ0  = 1'b0;
        ADDR0 = 5'd0;
        LAST0 = 1'b0;
        REQ1  = 1'b0;
        ADDR1 = 5'd0;
        LAST1 = 1'b0;

        // T1: reset holds everything low even with both requesting
        $display("[TB] T1 reset");
        applyStimulus(1, 1, 5'd3, 0, 1, 5'd9, 0);
        mon_en = 1'b1;
        checkAll("t1.rst1", 0, 0, 0, 5'd0, 0);
        applyStimulus(1, 1, 5'd3, 0, 1, 5'd9, 0);
        checkAll("t1.rst2", 0, 0, 0, 5'd0, 0);
        applyStimulus(0, 1, 5'd3, 0, 1, 5'd9, 0);
        checkAll("t1.grant", 1, 0, 0, 5'd0, 0);

        // T2: engine alone, three cycles with LAST on the third, so 2 beats
        $display("[TB] T2 single requester");
        applyStimulus(1, 0, 5'd0, 0, 0, 5'd0, 0);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd17, 0);
        checkAll("t2.gnt", 0, 1, 0, 5'd0, 0);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd17, 0);
        checkAll("t2.beat1", 0, 1, 1, 5'd17, 1);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd17, 1);
        checkAll("t2.beat2", 0, 0, 1, 5'd17, 1);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0);
        checkAll("t2.idle", 0, 0, 0, 5'd17, 1);

        // T3: tie after reset goes to the core, then hands over with no gap
        $display("[TB] T3 tie");
        applyStimulus(1, 0, 5'd0, 0, 0, 5'd0, 0);
        applyStimulus(0, 1, 5'd4, 0, 1, 5'd22, 0);
        checkAll("t3.gnt0", 1, 0, 0, 5'd0, 0);
        applyStimulus(0, 1, 5'd4, 1, 1, 5'd22, 0);
        checkAll("t3.handover", 0, 1, 1, 5'd4, 0);
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd22, 1);
        checkAll("t3.engine", 0, 0, 1, 5'd22, 1);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0);
        checkAll("t3.idle", 0, 0, 0, 5'd22, 1);

        // T4a: engine waits from the core's 3rd beat; core gets exactly 8 beats
        $display("[TB] T4 hold bound");
        applyStimulus(1, 0, 5'd0, 0, 0, 5'd0, 0);
        applyStimulus(0, 1, 5'd1, 0, 0, 5'd0, 0);
        checkAll("t4.gnt0", 1, 0, 0, 5'd0, 0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1, 5'(k), 0, (k >= 3), 5'd30, 0);
            checkAll($sformatf("t4.beat%0d", k), (k < 8), (k == 8), 1, 5'(k), 0);
        end
        applyStimulus(0, 0, 5'd0, 0, 1, 5'd30, 1);
        checkAll("t4.engine", 0, 0, 1, 5'd30, 1);

        // T4b: engine idle, so the core keeps the grant past MAX_HOLD beats
        applyStimulus(1, 0, 5'd0, 0, 0, 5'd0, 0);
        applyStimulus(0, 1, 5'd1, 0, 0, 5'd0, 0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 1, 5'(k), 0, 0, 5'd0, 0);
            checkAll($sformatf("t4.solo%0d", k), 1, 0, 1, 5'(k), 0);
        end
        // The counter is saturated, so a newly waiting engine forces release at once
        applyStimulus(0, 1, 5'd13, 0, 1, 5'd11, 0);
        checkAll("t4.late", 0, 1, 1, 5'd13, 0);

        // T5: reset while the engine streams, then the core wins the tie
        $display("[TB] T5 reset mid-tenure");
        applyStimulus(0, 1, 5'd13, 0, 1, 5'd11, 0);
        checkAll("t5.stream", 0, 1, 1, 5'd11, 1);
        applyStimulus(1, 1, 5'd13, 0, 1, 5'd12, 0);
        checkAll("t5.rst", 0, 0, 0, 5'd0, 0);
        applyStimulus(0, 1, 5'd13, 0, 1, 5'd12, 0);
        checkAll("t5.rr", 1, 0, 0, 5'd0, 0);
        applyStimulus(0, 0, 5'd0, 0, 0, 5'd0, 0);
        checkAll("t5.drop", 0, 0, 0, 5'd0, 0);

        @(negedge CLK);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
